// File: rtl/hyperram_rd_capture.sv
// HyperRAM read-path DDR capture: pairs rising/falling DQ bytes into words,
// counts them against a burst length and buffers them in a show-ahead FIFO.
module hyperram_rd_capture #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DQ,
  input  logic        RWDS,
  input  logic        START,
  input  logic [7:0]  LEN,
  input  logic        RD_EN,
  output logic [15:0] DOUT,
  output logic        DVALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        TOUT_ERR,
  output logic        OVERFLOW
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RECV
  } state_t;

  state_t      state;
  logic [7:0]  rb;
  logic        rs;
  logic [7:0]  fb;
  logic        fs;
  logic [7:0]  a_hi;
  logic [7:0]  a_lo;
  logic        a_rs;
  logic        a_fs;
  logic [7:0]  len;
  logic [7:0]  cnt;
  logic [7:0]  tcnt;
  logic [7:0]  tnext;
  logic        busy;
  logic        done;
  logic        tout;
  logic        ovf;

  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   occ;

  logic word_ok;
  logic acc;
  logic full;
  logic empty;
  logic push;
  logic pop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rb   <= '0;
      rs   <= 1'b0;
      a_hi <= '0;
      a_lo <= '0;
      a_rs <= 1'b0;
      a_fs <= 1'b0;
    end else begin
      rb   <= DQ;
      rs   <= RWDS;
      a_hi <= rb;
      a_lo <= fb;
      a_rs <= rs;
      a_fs <= fs;
    end
  end

  always_ff @(negedge CLK) begin
    if (RST) begin
      fb <= '0;
      fs <= 1'b0;
    end else begin
      fb <= DQ;
      fs <= RWDS;
    end
  end

  assign word_ok = a_rs & ~a_fs;
  assign acc     = word_ok & (state != IDLE);
  assign empty   = (occ == '0);
  assign full    = (occ == (AW+1)'(DEPTH));
  // A full FIFO still takes the word when the head is popped the same edge.
  assign push    = acc & (~full | RD_EN);
  assign pop     = RD_EN & ~empty;
  assign tnext   = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;

  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= {a_hi, a_lo};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      len   <= '0;
      cnt   <= '0;
      tcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      tout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      tout <= 1'b0;
      if (acc && full && !RD_EN) ovf <= 1'b1;
      unique case (state)
        IDLE: begin
          if (START) begin
            if (LEN == 8'd0) begin
              done <= 1'b1;
            end else begin
              state <= WAIT;
              len   <= LEN;
              cnt   <= '0;
              tcnt  <= '0;
              busy  <= 1'b1;
              ovf   <= 1'b0;
            end
          end
        end
        WAIT, RECV: begin
          if (acc) begin
            cnt   <= cnt + 8'd1;
            tcnt  <= '0;
            state <= RECV;
            if (cnt + 8'd1 == len) begin
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tcnt <= tnext;
            if (tnext == 8'(TIMEOUT)) begin
              tout  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign DOUT     = empty ? 16'h0000 : mem[rp];
  assign DVALID   = ~empty;
  assign BUSY     = busy;
  assign DONE     = done;
  assign TOUT_ERR = tout;
  assign OVERFLOW = ovf;

endmodule

// File: tb/tb_hyperram_rd_capture.sv
// Directed bench for hyperram_rd_capture: bursts, timeout,
// overflow, full-FIFO streaming, zero length and mid-burst reset.
module tb_hyperram_rd_capture;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  DQ;
  logic        RWDS;
  logic        START;
  logic [7:0]  LEN;
  logic        RD_EN;
  logic [15:0] DOUT;
  logic        DVALID;
  logic        BUSY;
  logic        DONE;
  logic        TOUT_ERR;
  logic        OVERFLOW;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int tout_cnt = 0;
  logic [15:0] q[$];

  hyperram_rd_capture #(.DEPTH(8), .TIMEOUT(32)) dut (
    .CLK(CLK),
    .RST(RST),
    .DQ(DQ),
    .RWDS(RWDS),
    .START(START),
    .LEN(LEN),
    .RD_EN(RD_EN),
    .DOUT(DOUT),
    .DVALID(DVALID),
    .BUSY(BUSY),
    .DONE(DONE),
    .TOUT_ERR(TOUT_ERR),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Pops commit at the next rising edge, so record the head here.
  always @(negedge CLK) begin
    if (DONE) done_cnt++;
    if (TOUT_ERR) tout_cnt++;
    if (RD_EN && DVALID) q.push_back(DOUT);
  end

  function automatic logic [15:0] exp_word(input logic [7:0] hb,
                                           input logic [7:0] lb,
                                           input int i);
    logic [7:0] h;
    logic [7:0] l;
    h = 8'(hb + 8'(17 * i));
    l = 8'(lb + 8'(17 * i));
    return {h, l};
  endfunction

  task automatic start_burst(input logic [7:0] l);
    @(posedge CLK);
    #1 START = 1'b1;
    LEN = l;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic send(input int n, input logic [7:0] hb,
                      input logic [7:0] lb, input int rd_from);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = exp_word(hb, lb, i);
      @(negedge CLK);
      #1 DQ = w[15:8];
      RWDS = 1'b1;
      @(posedge CLK);
      #1 DQ = w[7:0];
      RWDS = 1'b0;
      if (i == rd_from) RD_EN = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    RD_EN = 1'b1;
    for (int k = 0; k < 40 && DVALID; k++) begin
      @(posedge CLK);
      #1;
    end
    RD_EN = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle(3);
    checks++;
    if (DOUT !== 16'h0 || DVALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: dout=%h dvalid=%b busy=%b want 0000 0 0",
               DOUT, DVALID, BUSY);
    end
    checks++;
    if (DONE !== 1'b0 || TOUT_ERR !== 1'b0 || OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: done=%b tout=%b ovf=%b want 0 0 0",
               DONE, TOUT_ERR, OVERFLOW);
    end
    RST = 1'b0;
    idle(2);
  endtask

  task automatic test_burst4();
    int qb;
    int d0;
    qb = q.size();
    d0 = done_cnt;
    start_burst(8'd4);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL burst4_busy: got %b want 1", BUSY);
    end
    send(4, 8'hA1, 8'h11, -1);
    idle(4);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL burst4_done: got %0d pulses want 1", done_cnt - d0);
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL burst4_busy_end: got %b want 0", BUSY);
    end
    checks++;
    if (DVALID !== 1'b1 || DOUT !== 16'hA111) begin
      errors++;
      $display("FAIL burst4_head: dvalid=%b dout=%h want 1 a111",
               DVALID, DOUT);
    end
    drain();
    checks++;
    if (q.size() - qb !== 4 || DVALID !== 1'b0) begin
      errors++;
      $display("FAIL burst4_count: got %0d words dvalid=%b want 4 0",
               q.size() - qb, DVALID);
    end
    for (int k = 0; k < 4 && qb + k < q.size(); k++) begin
      checks++;
      if (q[qb+k] !== exp_word(8'hA1, 8'h11, k)) begin
        errors++;
        $display("FAIL burst4_word%0d: got %h want %h",
                 k, q[qb+k], exp_word(8'hA1, 8'h11, k));
      end
    end
  endtask

  task automatic test_timeout();
    int d0;
    int t0;
    d0 = done_cnt;
    t0 = tout_cnt;
    start_burst(8'd3);
    repeat (31) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (TOUT_ERR !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL tout_early: tout=%b busy=%b want 0 1", TOUT_ERR, BUSY);
    end
    @(negedge CLK);
    checks++;
    if (TOUT_ERR !== 1'b1) begin
      errors++;
      $display("FAIL tout_pulse: got %b want 1", TOUT_ERR);
    end
    @(negedge CLK);
    checks++;
    if (TOUT_ERR !== 1'b0 || BUSY !== 1'b0 || DVALID !== 1'b0) begin
      errors++;
      $display("FAIL tout_after: tout=%b busy=%b dvalid=%b want 0 0 0",
               TOUT_ERR, BUSY, DVALID);
    end
    checks++;
    if (done_cnt - d0 !== 0 || tout_cnt - t0 !== 1) begin
      errors++;
      $display("FAIL tout_counts: done=%0d tout=%0d want 0 1",
               done_cnt - d0, tout_cnt - t0);
    end
  endtask

  task automatic test_overflow();
    int qb;
    int d0;
    qb = q.size();
    d0 = done_cnt;
    start_burst(8'd10);
    send(10, 8'h10, 8'h01, -1);
    idle(4);
    checks++;
    if (OVERFLOW !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got %b want 1", OVERFLOW);
    end
    checks++;
    if (done_cnt - d0 !== 1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL ovf_done: done=%0d busy=%b want 1 0",
               done_cnt - d0, BUSY);
    end
    drain();
    checks++;
    if (q.size() - qb !== 8) begin
      errors++;
      $display("FAIL ovf_count: got %0d words want 8", q.size() - qb);
    end
    for (int k = 0; k < 8 && qb + k < q.size(); k++) begin
      checks++;
      if (q[qb+k] !== exp_word(8'h10, 8'h01, k)) begin
        errors++;
        $display("FAIL ovf_word%0d: got %h want %h",
                 k, q[qb+k], exp_word(8'h10, 8'h01, k));
      end
    end
  endtask

  task automatic test_full_stream();
    int qb;
    int d0;
    qb = q.size();
    d0 = done_cnt;
    start_burst(8'd12);
    send(12, 8'h20, 8'h02, 9);
    idle(2);
    drain();
    checks++;
    if (OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL stream_ovf: got %b want 0", OVERFLOW);
    end
    checks++;
    if (done_cnt - d0 !== 1 || q.size() - qb !== 12) begin
      errors++;
      $display("FAIL stream_count: done=%0d words=%0d want 1 12",
               done_cnt - d0, q.size() - qb);
    end
    for (int k = 0; k < 12 && qb + k < q.size(); k++) begin
      checks++;
      if (q[qb+k] !== exp_word(8'h20, 8'h02, k)) begin
        errors++;
        $display("FAIL stream_word%0d: got %h want %h",
                 k, q[qb+k], exp_word(8'h20, 8'h02, k));
      end
    end
  endtask

  task automatic test_len0_and_restart();
    int qb;
    int d0;
    start_burst(8'd0);
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL len0_done: done=%b busy=%b want 1 0", DONE, BUSY);
    end
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL len0_after: done=%b busy=%b want 0 0", DONE, BUSY);
    end
    qb = q.size();
    d0 = done_cnt;
    start_burst(8'd4);
    send(2, 8'h30, 8'h03, -1);
    start_burst(8'd1);
    idle(1);
    checks++;
    if (BUSY !== 1'b1 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL restart_ignored: busy=%b done=%0d want 1 0",
               BUSY, done_cnt - d0);
    end
    send(2, 8'h52, 8'h25, -1);
    idle(4);
    checks++;
    if (done_cnt - d0 !== 1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: done=%0d busy=%b want 1 0",
               done_cnt - d0, BUSY);
    end
    drain();
    checks++;
    if (q.size() - qb !== 4) begin
      errors++;
      $display("FAIL restart_count: got %0d words want 4", q.size() - qb);
    end
    for (int k = 0; k < 4 && qb + k < q.size(); k++) begin
      checks++;
      if (q[qb+k] !== exp_word(8'h30, 8'h03, k)) begin
        errors++;
        $display("FAIL restart_word%0d: got %h want %h",
                 k, q[qb+k], exp_word(8'h30, 8'h03, k));
      end
    end
  endtask

  task automatic test_mid_reset();
    int d0;
    int t0;
    d0 = done_cnt;
    t0 = tout_cnt;
    start_burst(8'd5);
    send(2, 8'h40, 8'h04, -1);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (DOUT !== 16'h0 || DVALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_data: dout=%h dvalid=%b busy=%b want 0000 0 0",
               DOUT, DVALID, BUSY);
    end
    checks++;
    if (DONE !== 1'b0 || TOUT_ERR !== 1'b0 || OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: done=%b tout=%b ovf=%b want 0 0 0",
               DONE, TOUT_ERR, OVERFLOW);
    end
    idle(40);
    checks++;
    if (done_cnt - d0 !== 0 || tout_cnt - t0 !== 0 || DVALID !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet: done=%0d tout=%0d dvalid=%b want 0 0 0",
               done_cnt - d0, tout_cnt - t0, DVALID);
    end
  endtask

  initial begin
    RST = 1'b1;
    DQ = 8'h00;
    RWDS = 1'b0;
    START = 1'b0;
    LEN = 8'h00;
    RD_EN = 1'b0;
    test_reset();
    test_burst4();
    test_timeout();
    test_overflow();
    test_full_stream();
    test_len0_and_restart();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
